// File: rtl/booth_seq_pkg.sv
// Shared types for the Booth multiplier front-end sequencer: FSM state
// encoding, default operand width and the full-width product type.
package booth_seq_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_Q,
    S_WAIT,
    S_CAP_LO,
    S_OUT
  } seq_state_e;

  typedef logic signed [2*DEF_WIDTH-1:0] prod_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand-pair FIFO. Depth must be a power of two so the
// read/write pointers wrap naturally. No bypass: a word written into an
// empty FIFO appears on rdata one cycle later. Push into a full FIFO and
// pop from an empty FIFO are ignored.
module booth_op_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Front-end sequencer for the serial Booth multiplier. Buffers signed
// operand pairs, loads multiplicand then multiplier into the multiplier,
// waits for done, collects the high then low product halves and presents
// the full-width product on a valid/ready port. One multiplication in
// flight at a time.
// Optional build macro: BOOTH_SEQ_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts with out_err=1 and a zero product after TIMEOUT cycles.
module booth_mul_sequencer
  import booth_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_a,
  input  logic signed [WIDTH-1:0]   in_b,
  output logic                      mul_start,
  output logic signed [WIDTH-1:0]   mul_data,
  input  logic                      mul_done,
  input  logic signed [WIDTH-1:0]   mul_dout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out_prod,
  output logic                      out_err,
  output logic                      busy
);

  localparam int PW = 2 * WIDTH;

  if (TIMEOUT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("booth_mul_sequencer: illegal TIMEOUT or FIFO_DEPTH");
  end

  seq_state_e              state;
  logic signed [WIDTH-1:0] b_r;
  logic signed [WIDTH-1:0] hi_r;
  logic signed [WIDTH-1:0] head_a;
  logic signed [WIDTH-1:0] head_b;
  logic [PW-1:0]           fifo_wdata;
  logic [PW-1:0]           fifo_rdata;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign fifo_wdata = {in_a, in_b};
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty;
  assign head_a     = fifo_rdata[PW-1:WIDTH];
  assign head_b     = fifo_rdata[WIDTH-1:0];
  assign in_ready   = !fifo_full;

  booth_op_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign out_err = 1'b0;
`endif

  // Operand and high-half capture. The multiplicand is driven straight from
  // the FIFO head onto mul_data at the pop edge, so only the multiplier
  // operand needs holding for the following load cycle.
  always_ff @(posedge clk) begin
    if (fifo_pop)                    b_r  <= head_b;
    if (state == S_WAIT && mul_done) hi_r <= mul_dout;
  end

  // Sequencer FSM; every output is registered and reflects the state entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mul_start <= 1'b0;
      mul_data  <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      busy      <= 1'b0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
      out_err   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state     <= S_LOAD_M;
            mul_start <= 1'b1;
            mul_data  <= head_a;
            busy      <= 1'b1;
          end
        end
        S_LOAD_M: begin
          state     <= S_LOAD_Q;
          mul_start <= 1'b0;
          mul_data  <= b_r;
        end
        S_LOAD_Q: begin
          state    <= S_WAIT;
          mul_data <= '0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
          wd_cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_done) begin
            state <= S_CAP_LO;
          end
`ifdef BOOTH_SEQ_TIMEOUT_EN
          else if (wd_expire) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_prod  <= '0;
            out_err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        S_CAP_LO: begin
          // Low half is on mul_dout this cycle; assemble {hi,lo} directly.
          state     <= S_OUT;
          out_valid <= 1'b1;
          out_prod  <= {hi_r, mul_dout};
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
            out_err   <= 1'b0;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Testbench for booth_mul_sequencer: behavioural serial multiplier model
// (done 12 cycles after start, hi then lo on data_out) plus a queue of
// expected products computed with plain signed arithmetic.
module tb_booth_mul_sequencer;
  import booth_seq_pkg::*;

  localparam int WIDTH      = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int TIMEOUT    = 64;
  localparam int DONE_DELAY = 12;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_a = '0;
  logic signed [WIDTH-1:0]   in_b = '0;
  logic                      mul_start;
  logic signed [WIDTH-1:0]   mul_data;
  logic                      mul_done;
  logic signed [WIDTH-1:0]   mul_dout;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic signed [2*WIDTH-1:0] out_prod;
  logic                      out_err;
  logic                      busy;

  int vectors     = 0;
  int miscompares = 0;

  prod_t exp_q[$];

  booth_mul_sequencer #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_data  (mul_data),
    .mul_done  (mul_done),
    .mul_dout  (mul_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural serial multiplier
  logic                      model_no_done = 1'b0;
  int                        start_count = 0;
  int                        model_cnt = 0;
  logic signed [WIDTH-1:0]   seen_m = '0;
  logic signed [WIDTH-1:0]   seen_q = '0;
  logic signed [2*WIDTH-1:0] model_prod;

  assign model_prod = seen_m * seen_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_cnt <= 0;
      mul_done  <= 1'b0;
      mul_dout  <= '0;
    end else begin
      mul_done <= 1'b0;
      mul_dout <= '0;
      if (mul_start) begin
        start_count <= start_count + 1;
        seen_m      <= mul_data;
        model_cnt   <= 1;
      end else if (model_cnt != 0) begin
        model_cnt <= model_cnt + 1;
        if (model_cnt == 1) seen_q <= mul_data;
        if (model_cnt == DONE_DELAY - 1 && !model_no_done) begin
          mul_done <= 1'b1;
          mul_dout <= model_prod[2*WIDTH-1:WIDTH];
        end
        if (model_cnt == DONE_DELAY && !model_no_done) begin
          mul_dout  <= model_prod[WIDTH-1:0];
          model_cnt <= 0;
        end
      end
    end
  end

  function automatic prod_t ref_mul(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b);
    prod_t x = a;
    prod_t y = b;
    return x * y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic signed [WIDTH-1:0] a,
                           input logic signed [WIDTH-1:0] b,
                           output bit ok);
    int guard = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    ok = (in_ready === 1'b1);
    tick();
    in_valid = 1'b0;
    if (ok) exp_q.push_back(ref_mul(a, b));
  endtask

  task automatic collect(input int stall, output prod_t p, output logic e, output bit ok);
    int guard = 0;
    while (out_valid !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    ok = (out_valid === 1'b1);
    repeat (stall) tick();
    p = out_prod;
    e = out_err;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    rst_n = 1'b0;
    tick();
    tick();
    obs = {in_ready, mul_start, mul_data, out_valid, out_prod, out_err, busy};
    vectors++;
    if (obs !== {1'b1, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", obs, {1'b1, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || mul_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b mul_start=%b want 0 0", busy, mul_start);
    end
  endtask

  task automatic test_latency();
    bit ok;
    push_pair(-5'sd10, 5'sd13, ok);
    vectors++;
    if (!ok || mul_start !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_no_bypass: ok=%0d mul_start=%b want 1 0", ok, mul_start);
    end
    tick();
    vectors++;
    if (mul_start !== 1'b1 || mul_data !== 5'h16) begin
      miscompares++;
      $display("FAIL lat_load_m: start=%b data=%h want 1 16", mul_start, mul_data);
    end
    tick();
    vectors++;
    if (mul_start !== 1'b0 || mul_data !== 5'h0D) begin
      miscompares++;
      $display("FAIL lat_load_q: start=%b data=%h want 0 0d", mul_start, mul_data);
    end
    tick();
    vectors++;
    if (mul_data !== 5'h00 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL lat_wait: data=%h busy=%b want 00 1", mul_data, busy);
    end
    repeat (11) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_early_valid: out_valid=%b want 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_prod !== 10'h37E || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_product: valid=%b prod=%h err=%b want 1 37e 0", out_valid, out_prod, out_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_accept: valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_corners();
    logic signed [WIDTH-1:0] ta[2] = '{-5'sd16, -5'sd16};
    logic signed [WIDTH-1:0] tb[2] = '{-5'sd16, 5'sd15};
    logic [9:0]              te[2] = '{10'h100, 10'h310};
    prod_t p;
    logic  e;
    bit    ok;
    bit    okp;
    for (int i = 0; i < 2; i++) begin
      push_pair(ta[i], tb[i], okp);
      collect(0, p, e, ok);
      void'(exp_q.pop_front());
      vectors++;
      if (!okp || !ok || {e, p} !== {1'b0, te[i]}) begin
        miscompares++;
        $display("FAIL corner_%0d: ok=%0d/%0d err=%b prod=%h want err=0 prod=%h", i, okp, ok, e, p, te[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int    s0;
    prod_t p;
    prod_t exp;
    logic  e;
    bit    ok;
    bit    okp;
    logic [31:0] r;
    s0 = start_count;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      push_pair(r[4:0], r[12:8], okp);
      vectors++;
      if (!okp) begin
        miscompares++;
        $display("FAIL fifo_push_%0d: push not accepted", i);
      end
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full_ready: in_ready=%b want 0", in_ready);
    end
    repeat (5) tick();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full_hold: in_ready=%b want 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      collect(0, p, e, ok);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      vectors++;
      if (!ok || {e, p} !== {1'b0, exp}) begin
        miscompares++;
        $display("FAIL fifo_order_%0d: ok=%0d err=%b prod=%h want err=0 prod=%h", i, ok, e, p, exp);
      end
    end
    vectors++;
    if (start_count - s0 !== 3) begin
      miscompares++;
      $display("FAIL fifo_start_count: got %0d want 3", start_count - s0);
    end
  endtask

  task automatic test_backpressure();
    int    s0;
    int    guard = 0;
    prod_t held;
    prod_t exp;
    prod_t p;
    logic  e;
    bit    ok;
    bit    okp;
    push_pair(5'sd7, -5'sd3, okp);
    push_pair(-5'sd8, 5'sd11, okp);
    while (out_valid !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    s0   = start_count;
    held = out_prod;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_prod !== held || busy !== 1'b1 || mul_start !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_%0d: valid=%b prod=%h busy=%b start=%b want 1 %h 1 0",
                 i, out_valid, out_prod, busy, mul_start, held);
      end
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    vectors++;
    if (held !== exp || start_count !== s0) begin
      miscompares++;
      $display("FAIL stall_result: prod=%h starts=%0d want %h %0d", held, start_count, exp, s0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    collect(2, p, e, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    vectors++;
    if (!ok || {e, p} !== {1'b0, exp}) begin
      miscompares++;
      $display("FAIL stall_second: ok=%0d err=%b prod=%h want err=0 prod=%h", ok, e, p, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] obs;
    int    s0;
    int    guard = 0;
    prod_t p;
    logic  e;
    bit    ok;
    bit    okp;
    s0 = start_count;
    push_pair(5'sd7, 5'sd9, okp);
    push_pair(5'sd2, 5'sd3, okp);
    while (start_count == s0 && guard < 50) begin
      tick();
      guard++;
    end
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    obs = {in_ready, mul_start, mul_data, out_valid, out_prod, out_err, busy};
    vectors++;
    if (obs !== {1'b1, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h want %h", obs, {1'b1, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 1'b0});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || mul_start !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_empty_%0d: busy=%b start=%b valid=%b want 0 0 0", i, busy, mul_start, out_valid);
      end
    end
    push_pair(5'sd3, -5'sd5, okp);
    collect(0, p, e, ok);
    void'(exp_q.pop_front());
    vectors++;
    if (!okp || !ok || {e, p} !== {1'b0, 10'h3F1}) begin
      miscompares++;
      $display("FAIL midreset_next: ok=%0d/%0d err=%b prod=%h want err=0 prod=3f1", okp, ok, e, p);
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    fork
      begin
        logic [31:0] r;
        logic signed [WIDTH-1:0] a;
        logic signed [WIDTH-1:0] b;
        bit okp;
        for (int i = 0; i < N; i++) begin
          r = $urandom;
          a = (r[17:16] == 2'd0) ? -5'sd16 : r[4:0];
          b = (r[19:18] == 2'd0) ? 5'sd15  : r[12:8];
          repeat (r[21:20]) tick();
          push_pair(a, b, okp);
          vectors++;
          if (!okp) begin
            miscompares++;
            $display("FAIL rand_push_%0d: push not accepted", i);
          end
        end
      end
      begin
        prod_t p;
        prod_t exp;
        logic  e;
        bit    ok;
        for (int j = 0; j < N; j++) begin
          collect($urandom_range(0, 3), p, e, ok);
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          vectors++;
          if (!ok || {e, p} !== {1'b0, exp}) begin
            miscompares++;
            $display("FAIL rand_result_%0d: ok=%0d err=%b prod=%h want err=0 prod=%h", j, ok, e, p, exp);
          end
        end
      end
    join
  endtask

`ifdef BOOTH_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int    s0;
    int    guard = 0;
    prod_t p;
    logic  e;
    bit    ok;
    bit    okp;
    model_no_done = 1'b1;
    s0 = start_count;
    push_pair(5'sd5, 5'sd6, okp);
    while (start_count == s0 && guard < 50) begin
      tick();
      guard++;
    end
    repeat (60) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: out_valid=%b want 0", out_valid);
    end
    collect(0, p, e, ok);
    void'(exp_q.pop_front());
    vectors++;
    if (!ok || {e, p} !== {1'b1, 10'h000}) begin
      miscompares++;
      $display("FAIL timeout_abort: ok=%0d err=%b prod=%h want err=1 prod=000", ok, e, p);
    end
    model_no_done = 1'b0;
    push_pair(5'sd4, -5'sd3, okp);
    collect(0, p, e, ok);
    void'(exp_q.pop_front());
    vectors++;
    if (!okp || !ok || {e, p} !== {1'b0, 10'h3F4}) begin
      miscompares++;
      $display("FAIL timeout_recover: ok=%0d/%0d err=%b prod=%h want err=0 prod=3f4", okp, ok, e, p);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_fifo_full();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef BOOTH_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_mul_sequencer.md
Name: booth_mul_sequencer

Overview:
Upstream front-end for the serial Booth multiplier datapath/controller pair. It buffers signed operand pairs in a small FIFO and drives the multiplier's start/data_in load sequence (multiplicand, then multiplier). It waits for done, collects the two product halves from data_out, and presents a full-width signed product on a valid/ready output. Only one multiplication is in flight at a time.

Parameters:
WIDTH, 5, operand width; must match the multiplier's data_in/data_out width.
FIFO_DEPTH, 2, operand-pair FIFO entries; power of two, ≥2.
TIMEOUT, 64, watchdog limit in WAIT cycles; used only with BOOTH_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  operand pair offered.
in_ready  out  1  FIFO not full.
in_a  in  WIDTH  signed multiplicand.
in_b  in  WIDTH  signed multiplier.
mul_start  out  1  to multiplier start.
mul_data  out  WIDTH  to multiplier data_in.
mul_done  in  1  from multiplier done.
mul_dout  in  WIDTH  from multiplier data_out.
out_valid  out  1  product available.
out_ready  in  1  consumer accepts product.
out_prod  out  2*WIDTH  signed product {hi,lo}.
out_err  out  1  product aborted by watchdog; tied 0 without macro.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset, rst_n low at an edge: FSM to IDLE, FIFO emptied, watchdog cleared. Outputs: in_ready=1, mul_start=0, mul_data=0, out_valid=0, out_prod=0, out_err=0, busy=0.
- Reset mid-operation aborts the operation. No product is emitted. The multiplier is expected to be reset alongside.
- FIFO push occurs on in_valid&&in_ready. in_ready=!full. No bypass: a pair pushed into an empty FIFO is visible to the FSM in the next cycle. A push and a pop in the same cycle are legal when the FIFO is neither full nor empty.
- FSM states: IDLE, LOAD_M, LOAD_Q, WAIT, CAP_LO, OUT. All outputs are registered.
- IDLE: FIFO non-empty -> LOAD_M. The head entry is popped into internal a_r/b_r.
- LOAD_M (1 cycle): mul_start=1, mul_data=a_r -> LOAD_Q.
- LOAD_Q (1 cycle): mul_start=0, mul_data=b_r -> WAIT.
- WAIT: mul_data=0. On mul_done=1, capture mul_dout into hi_r -> CAP_LO.
- CAP_LO: capture mul_dout into lo_r -> OUT.
- mul_done is ignored outside WAIT.
- OUT: out_valid=1; out_prod={hi_r,lo_r} holds stable until out_ready=1, then -> IDLE with out_valid cleared at that edge. No new mul_start is issued while in OUT.
- Latency, push into empty FIFO while IDLE at edge N: mul_start high in cycle N+2; out_valid high 2 cycles after the cycle in which mul_done was sampled.
- Product arithmetic is two's complement. The range for WIDTH=5 is -16*-16=+256 to -16*15=-240; no overflow is possible in 2*WIDTH bits.

Optional Feature:
BOOTH_SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT. When TIMEOUT cycles elapse without mul_done, go to OUT with out_prod=0 and out_err=1. out_err clears when the result is accepted. The counter clears on every entry to WAIT.
- Not defined: WAIT lasts indefinitely; out_err is constant 0 and no counter logic is synthesised.

Decomposition:
- Package booth_seq_pkg holds:
  - the state enum type (IDLE..OUT);
  - default WIDTH;
  - a product typedef of width 2*WIDTH.
- Sub-module booth_op_fifo, a synchronous FIFO with parameterised depth and data width 2*WIDTH. It has push, pop, full and empty, and the same clk/rst_n.

Test Plan:
- The bench drives a behavioural multiplier model. The model raises done 12 cycles after start, and drives hi on data_out in the done cycle and lo in the next cycle.
- Push a=-10 (5'h16), b=13 (5'h0D) -> mul_start pulse with mul_data=5'h16, next cycle mul_data=5'h0D; out_prod=10'h37E (-130), out_err=0.
- Push (-16,-16) -> out_prod=10'h100; push (-16,15) -> out_prod=10'h310 (-240).
- FIFO_DEPTH=2, three consecutive pushes -> in_ready=0 until the first pop. All three products come out in order, each with exactly one mul_start.
- Hold out_ready=0 for 10 cycles while out_valid=1 -> out_prod stable, busy=1, no mul_start.
- Drive rst_n=0 for one edge during WAIT -> next cycle all outputs at reset values and the FIFO is empty. A following op 3*-5 gives out_prod=10'h3F1 (-15).
- With BOOTH_SEQ_TIMEOUT_EN and the model never raising done -> after 64 WAIT cycles, out_valid=1, out_err=1, out_prod=0. The next op completes normally with out_err=0.
